boruhatti_fark_agaci: RTL and testbench
=======================================

Name: boruhatti_fark_agaci

Overview:
- Parametrised pipelined reduction block, streaming.
- Computes either |ΣA − ΣB| or ΣA + ΣB over two groups of K unsigned N-bit operands.
- Balanced registered adder tree per group, then one registered combine stage. Fully pipelined: one new operand set accepted every cycle.
- Sits between operand capture logic and result consumer; valid bit travels with data (no stall/backpressure).

Parameters:
- N, 8, operand width in bits (≥1).
- K, 4, operands per group; power of two, ≥2. Any other value is an elaboration error.
- Derived (localparam, not overridable): D = $clog2(K) tree depth; L = D+1 latency in cycles; OUT_W = N+D+1 result width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- giris_etkin  input  1  operand set valid this cycle
- fark_modu  input  1  1: absolute difference, 0: total sum; sampled with operands
- grup_a  input  K*N  group A operands packed; operand i at [i*N +: N]
- grup_b  input  K*N  group B operands, same packing
- sonuc  output  OUT_W  result
- sonuc_etkin  output  1  sonuc holds a new result this cycle

Behaviour:
- Reset: rst_n sampled low at a clk edge clears to 0:
  - all tree registers, mode bits and valid bits;
  - sonuc = 0, sonuc_etkin = 0.
  - Reset mid-operation discards all in-flight sets; no sonuc_etkin pulse for them after release.
  - First set accepted on the first edge with rst_n=1.
- Acceptance: edge t with giris_etkin=1 captures grup_a, grup_b, fark_modu.
- Tree:
  - Stage s (1..D) adds adjacent pairs from stage s−1; K/2^s sums of width N+s each.
  - Adds are zero-extended; no truncation, no overflow possible.
- Combine stage (stage D+1), on the two group totals SA and SB (width N+D):
  - fark_modu=1: sonuc = SA≥SB ? SA−SB : SB−SA, zero-extended to OUT_W.
  - fark_modu=0: sonuc = SA+SB.
  - Equal totals give 0 in difference mode.
- Latency: result of a set captured at edge t appears at edge t+L. sonuc_etkin is high for exactly the cycle following edge t+L.
- Valid pipeline: an L-deep shift register of valid bits runs alongside data, together with the mode bit.
  - Sets with giris_etkin=0 are bubbles: their data registers may update, but they never raise sonuc_etkin.
  - sonuc updates only when a valid set reaches it; otherwise it holds the last valid result (0 after reset).
- Back-to-back: consecutive valid sets produce consecutive sonuc_etkin pulses in input order.
- Mode may change every cycle. Each set uses its own captured mode.
- No handshake/ready: the consumer must accept every sonuc_etkin pulse.

Optional Feature:
- Macro: BORUHATTI_SAYAC_EN.
- Defined:
  - adds output port sonuc_sayisi [31:0]: count of sonuc_etkin pulses since reset;
  - increments on the same edge sonuc_etkin rises;
  - wraps 0xFFFFFFFF→0;
  - cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package boruhatti_pkg:
  - function for OUT_W from N and K;
  - localparam checks (K power of two, K≥2).
- Sub-module toplama_agaci (params N, K): registered balanced adder tree with valid-bit shift register.
  - D-cycle latency; output width N+D; synchronous active-low reset.
  - Instantiated twice (groups A and B).
- The top level adds the combine stage and the mode/valid pipeline alignment.

Test Plan (N=8, K=4, L=3, OUT_W=11):
- A={1,2,3,4}, B={5,6,7,8}, fark_modu=1, one valid set at edge t -> sonuc=16, sonuc_etkin=1 only in the cycle after edge t+3; sonuc stays 16 afterwards.
- Same operands, fark_modu=0 -> sonuc=36; then A={255×4}, B={255×4}, mode 0 -> sonuc=2040 (no overflow).
- Extremes in difference mode:
  - A all 255, B all 0 -> 1020;
  - A all 0, B all 255 -> 1020;
  - A={10,20,30,40}, B={25,25,25,25} -> 0.
- Back-to-back sets (fark, topla, fark) separated by one bubble (giris_etkin=0) -> results in order, pulses on matching cycles, no pulse for the bubble.
- Two valid sets in flight, rst_n low one edge, then high -> sonuc=0, sonuc_etkin stays 0 for the next 3 cycles.
- With BORUHATTI_SAYAC_EN: 5 valid sets -> sonuc_sayisi=5 after the last pulse; reset -> 0.

Source files
------------

// File: rtl/boruhatti_fark_agaci_pkg.sv
// Shared helpers for boruhatti_fark_agaci: result-width function and K legality check.
package boruhatti_pkg;

  function automatic int out_w_f(input int n, input int k);
    return n + $clog2(k) + 1;
  endfunction

  // The tree pairs operands level by level, so only powers of two >= 2 balance.
  function automatic bit k_gecerli(input int k);
    return (k >= 2) && ((k & (k - 1)) == 0);
  endfunction

endpackage

// File: rtl/boruhatti_fark_agaci_if.sv
// Operand/result bundle for boruhatti_fark_agaci; sonuc_sayisi exists only with BORUHATTI_SAYAC_EN.
interface boruhatti_fark_agaci_if
  import boruhatti_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 4
) ();

  localparam int OUT_W = out_w_f(N, K);

  logic             giris_etkin;
  logic             fark_modu;
  logic [K*N-1:0]   grup_a;
  logic [K*N-1:0]   grup_b;
  logic [OUT_W-1:0] sonuc;
  logic             sonuc_etkin;
`ifdef BORUHATTI_SAYAC_EN
  logic [31:0]      sonuc_sayisi;
`endif

  modport master (
    output giris_etkin,
    output fark_modu,
    output grup_a,
    output grup_b,
`ifdef BORUHATTI_SAYAC_EN
    input  sonuc_sayisi,
`endif
    input  sonuc,
    input  sonuc_etkin
  );

  modport slave (
    input  giris_etkin,
    input  fark_modu,
    input  grup_a,
    input  grup_b,
`ifdef BORUHATTI_SAYAC_EN
    output sonuc_sayisi,
`endif
    output sonuc,
    output sonuc_etkin
  );

endinterface

// File: rtl/boruhatti_fark_agaci_toplama_agaci.sv
// Registered balanced adder tree over K unsigned N-bit operands, D-cycle latency,
// with a valid bit shifted alongside the data.
module toplama_agaci
  import boruhatti_pkg::*;
#(
  parameter  int N = 8,
  parameter  int K = 4,
  localparam int D = $clog2(K)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           giris_etkin,
  input  logic [K*N-1:0] veri,
  output logic [N+D-1:0] toplam,
  output logic           cikis_etkin
);

  if (!k_gecerli(K)) begin : k_hatasi
    $error("toplama_agaci: K must be a power of two and at least 2");
  end

  logic [D-1:0] etkin_sr;

  // Level s holds K>>s sums, each one bit wider than its two inputs, so nothing is lost.
  for (genvar s = 1; s <= D; s++) begin : kat
    for (genvar i = 0; i < (K >> s); i++) begin : dugum
      logic [N+s-2:0] sol;
      logic [N+s-2:0] sag;
      logic [N+s-1:0] r;

      if (s == 1) begin : yaprak
        assign sol = veri[(2*i)*N +: N];
        assign sag = veri[(2*i+1)*N +: N];
      end else begin : ic
        assign sol = kat[s-1].dugum[2*i].r;
        assign sag = kat[s-1].dugum[2*i+1].r;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r <= '0;
        end else begin
          r <= {1'b0, sol} + {1'b0, sag};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      etkin_sr <= '0;
    end else begin
      etkin_sr[0] <= giris_etkin;
      for (int j = 1; j < D; j++) begin
        etkin_sr[j] <= etkin_sr[j-1];
      end
    end
  end

  assign toplam      = kat[D].dugum[0].r;
  assign cikis_etkin = etkin_sr[D-1];

endmodule

// File: rtl/boruhatti_fark_agaci.sv
// Streaming |sum(A) - sum(B)| or sum(A) + sum(B) over two operand groups, latency D+1.
// Optional macro BORUHATTI_SAYAC_EN adds a result pulse counter (sonuc_sayisi).
module boruhatti_fark_agaci
  import boruhatti_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  boruhatti_fark_agaci_if.slave bus
);

  localparam int D     = $clog2(K);
  localparam int OUT_W = out_w_f(N, K);

  if (!k_gecerli(K)) begin : k_hatasi
    $error("boruhatti_fark_agaci: K must be a power of two and at least 2");
  end

  logic [K*N-1:0]   a_r;
  logic [K*N-1:0]   b_r;
  logic             etkin_r;
  logic             mod_r;
  logic [D-1:0]     mod_sr;
  logic [N+D-1:0]   sa;
  logic [N+D-1:0]   sb;
  logic             etkin_a;
  logic             etkin_b;
  logic             etkin_hizali;
  logic             mod_hizali;
  logic [OUT_W-1:0] sonuc_d;
  logic [OUT_W-1:0] sonuc_q;
  logic             sonuc_etkin_q;

  // Capture stage: data is taken every cycle; only the valid bit distinguishes bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      etkin_r <= 1'b0;
      mod_r   <= 1'b0;
    end else begin
      a_r     <= bus.grup_a;
      b_r     <= bus.grup_b;
      etkin_r <= bus.giris_etkin;
      mod_r   <= bus.fark_modu;
    end
  end

  toplama_agaci #(.N(N), .K(K)) u_agac_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .giris_etkin (etkin_r),
    .veri        (a_r),
    .toplam      (sa),
    .cikis_etkin (etkin_a)
  );

  toplama_agaci #(.N(N), .K(K)) u_agac_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .giris_etkin (etkin_r),
    .veri        (b_r),
    .toplam      (sb),
    .cikis_etkin (etkin_b)
  );

  // The mode bit rides a D-deep shift so it meets its own set at the tree outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mod_sr <= '0;
    end else begin
      mod_sr[0] <= mod_r;
      for (int j = 1; j < D; j++) begin
        mod_sr[j] <= mod_sr[j-1];
      end
    end
  end

  assign mod_hizali   = mod_sr[D-1];
  assign etkin_hizali = etkin_a & etkin_b;

  always_comb begin
    sonuc_d = '0;
    if (mod_hizali) begin
      sonuc_d = (sa >= sb) ? {1'b0, sa - sb} : {1'b0, sb - sa};
    end else begin
      sonuc_d = {1'b0, sa} + {1'b0, sb};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sonuc_q       <= '0;
      sonuc_etkin_q <= 1'b0;
    end else begin
      sonuc_etkin_q <= etkin_hizali;
      if (etkin_hizali) begin
        sonuc_q <= sonuc_d;
      end
    end
  end

  assign bus.sonuc       = sonuc_q;
  assign bus.sonuc_etkin = sonuc_etkin_q;

`ifdef BORUHATTI_SAYAC_EN
  logic [31:0] sayac_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sayac_q <= '0;
    end else if (etkin_hizali) begin
      sayac_q <= sayac_q + 32'd1;
    end
  end

  assign bus.sonuc_sayisi = sayac_q;
`endif

endmodule

// File: tb/tb_boruhatti_fark_agaci.sv
// Directed self-checking bench for boruhatti_fark_agaci at N=8, K=4 (latency 3, 11-bit result).
module tb_boruhatti_fark_agaci;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  boruhatti_fark_agaci_if #(.N(8), .K(4)) bus ();

  boruhatti_fark_agaci #(.N(8), .K(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic [7:0] o0, input logic [7:0] o1,
                                     input logic [7:0] o2, input logic [7:0] o3);
    return {o3, o2, o1, o0};
  endfunction

  task automatic bos_giris();
    bus.giris_etkin = 1'b0;
    bus.fark_modu   = 1'b0;
    bus.grup_a      = '0;
    bus.grup_b      = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bos_giris();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.sonuc !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_sonuc: got %0d expected 0", bus.sonuc);
    end
    checks++;
    if (bus.sonuc_etkin !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_etkin: got %b expected 0", bus.sonuc_etkin);
    end
`ifdef BORUHATTI_SAYAC_EN
    checks++;
    if (bus.sonuc_sayisi !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_sayac: got %0d expected 0", bus.sonuc_sayisi);
    end
`endif
    rst_n = 1'b1;
  endtask

  // One difference-mode set; pulse must appear only on the sample after edge t+3, then result holds.
  task automatic test_fark_temel();
    @(negedge clk);
    bus.grup_a      = pk(8'd1, 8'd2, 8'd3, 8'd4);
    bus.grup_b      = pk(8'd5, 8'd6, 8'd7, 8'd8);
    bus.fark_modu   = 1'b1;
    bus.giris_etkin = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.sonuc_etkin !== (k == 4)) begin
        errors++;
        $display("[TB] FAIL fark_temel_etkin k=%0d: got %b expected %b", k, bus.sonuc_etkin, (k == 4));
      end
      checks++;
      if (bus.sonuc !== ((k >= 4) ? 11'd16 : 11'd0)) begin
        errors++;
        $display("[TB] FAIL fark_temel_sonuc k=%0d: got %0d expected %0d", k, bus.sonuc,
                 (k >= 4) ? 16 : 0);
      end
      if (k == 1) bos_giris();
    end
  endtask

  task automatic test_toplam_ve_uc();
    logic [31:0] av  [5];
    logic [31:0] bv  [5];
    logic        mv  [5];
    logic [10:0] exp_s [5];
    av[0] = pk(8'd1, 8'd2, 8'd3, 8'd4);         bv[0] = pk(8'd5, 8'd6, 8'd7, 8'd8);
    mv[0] = 1'b0; exp_s[0] = 11'd36;
    av[1] = pk(8'd255, 8'd255, 8'd255, 8'd255); bv[1] = pk(8'd255, 8'd255, 8'd255, 8'd255);
    mv[1] = 1'b0; exp_s[1] = 11'd2040;
    av[2] = pk(8'd255, 8'd255, 8'd255, 8'd255); bv[2] = pk(8'd0, 8'd0, 8'd0, 8'd0);
    mv[2] = 1'b1; exp_s[2] = 11'd1020;
    av[3] = pk(8'd0, 8'd0, 8'd0, 8'd0);         bv[3] = pk(8'd255, 8'd255, 8'd255, 8'd255);
    mv[3] = 1'b1; exp_s[3] = 11'd1020;
    av[4] = pk(8'd10, 8'd20, 8'd30, 8'd40);     bv[4] = pk(8'd25, 8'd25, 8'd25, 8'd25);
    mv[4] = 1'b1; exp_s[4] = 11'd0;
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      bus.grup_a      = av[v];
      bus.grup_b      = bv[v];
      bus.fark_modu   = mv[v];
      bus.giris_etkin = 1'b1;
      @(negedge clk);
      bos_giris();
      repeat (2) @(negedge clk);
      checks++;
      if (bus.sonuc_etkin !== 1'b0) begin
        errors++;
        $display("[TB] FAIL vektor%0d_erken_etkin: got %b expected 0", v, bus.sonuc_etkin);
      end
      @(negedge clk);
      checks++;
      if (bus.sonuc_etkin !== 1'b1) begin
        errors++;
        $display("[TB] FAIL vektor%0d_etkin: got %b expected 1", v, bus.sonuc_etkin);
      end
      checks++;
      if (bus.sonuc !== exp_s[v]) begin
        errors++;
        $display("[TB] FAIL vektor%0d_sonuc: got %0d expected %0d", v, bus.sonuc, exp_s[v]);
      end
    end
  endtask

  // Sets at input cycles 0, 2, 4 with bubbles between; pulses expected at samples 4, 6, 8.
  task automatic test_back_to_back();
    logic [31:0] av [5];
    logic [31:0] bv [5];
    logic        mv [5];
    logic        vv [5];
    logic [10:0] hold;
    logic [10:0] exp_r;
    logic        exp_e;
    av[0] = pk(8'd1, 8'd2, 8'd3, 8'd4);     bv[0] = pk(8'd5, 8'd6, 8'd7, 8'd8); mv[0] = 1'b1; vv[0] = 1'b1;
    av[1] = pk(8'd99, 8'd99, 8'd99, 8'd99); bv[1] = pk(8'd0, 8'd0, 8'd0, 8'd0); mv[1] = 1'b0; vv[1] = 1'b0;
    av[2] = pk(8'd100, 8'd50, 8'd25, 8'd5); bv[2] = pk(8'd1, 8'd1, 8'd1, 8'd1); mv[2] = 1'b0; vv[2] = 1'b1;
    av[3] = pk(8'd7, 8'd7, 8'd7, 8'd7);     bv[3] = pk(8'd1, 8'd0, 8'd0, 8'd0); mv[3] = 1'b1; vv[3] = 1'b0;
    av[4] = pk(8'd0, 8'd0, 8'd0, 8'd9);     bv[4] = pk(8'd3, 8'd3, 8'd3, 8'd3); mv[4] = 1'b1; vv[4] = 1'b1;
    hold = 11'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c > 0) begin
        exp_e = (c == 4) || (c == 6) || (c == 8);
        exp_r = (c == 4) ? 11'd16 : (c == 6) ? 11'd184 : (c == 8) ? 11'd3 : hold;
        checks++;
        if (bus.sonuc_etkin !== exp_e) begin
          errors++;
          $display("[TB] FAIL b2b_etkin c=%0d: got %b expected %b", c, bus.sonuc_etkin, exp_e);
        end
        if (c >= 4) begin
          checks++;
          if (bus.sonuc !== exp_r) begin
            errors++;
            $display("[TB] FAIL b2b_sonuc c=%0d: got %0d expected %0d", c, bus.sonuc, exp_r);
          end
          hold = exp_r;
        end
      end
      if (c < 5) begin
        bus.grup_a      = av[c];
        bus.grup_b      = bv[c];
        bus.fark_modu   = mv[c];
        bus.giris_etkin = vv[c];
      end else begin
        bos_giris();
      end
    end
  endtask

  task automatic test_reset_ucusta();
    @(negedge clk);
    bus.grup_a      = pk(8'd9, 8'd9, 8'd9, 8'd9);
    bus.grup_b      = pk(8'd1, 8'd1, 8'd1, 8'd1);
    bus.fark_modu   = 1'b1;
    bus.giris_etkin = 1'b1;
    @(negedge clk);
    bus.fark_modu   = 1'b0;
    @(negedge clk);
    bos_giris();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.sonuc_etkin !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ucusta_reset_etkin k=%0d: got %b expected 0", k, bus.sonuc_etkin);
      end
      checks++;
      if (bus.sonuc !== 11'd0) begin
        errors++;
        $display("[TB] FAIL ucusta_reset_sonuc k=%0d: got %0d expected 0", k, bus.sonuc);
      end
      @(negedge clk);
    end
  endtask

`ifdef BORUHATTI_SAYAC_EN
  task automatic test_sayac();
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      bus.grup_a      = pk(8'(v), 8'd1, 8'd1, 8'd1);
      bus.grup_b      = pk(8'd0, 8'd0, 8'd0, 8'd0);
      bus.fark_modu   = 1'b0;
      bus.giris_etkin = 1'b1;
    end
    @(negedge clk);
    bos_giris();
    repeat (5) @(negedge clk);
    checks++;
    if (bus.sonuc_sayisi !== 32'd5) begin
      errors++;
      $display("[TB] FAIL sayac_bes: got %0d expected 5", bus.sonuc_sayisi);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (bus.sonuc_sayisi !== 32'd0) begin
      errors++;
      $display("[TB] FAIL sayac_reset: got %0d expected 0", bus.sonuc_sayisi);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bos_giris();
    test_reset();
    test_fark_temel();
    test_toplam_ve_uc();
    test_back_to_back();
    test_reset_ucusta();
`ifdef BORUHATTI_SAYAC_EN
    test_sayac();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
